// File: rtl/inputbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inputbuf_pkg
// Purpose : Shared definitions for the ping-pong input buffer controller:
//           the clog2-based width helper and the bank index constants.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package inputbuf_pkg;

  // Bit width needed to index 'value' items, never less than one bit so
  // that degenerate sizes still produce a legal vector.
  function automatic int width_of(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/inputbuf_rd_seq.sv
`default_nettype none
// ============================================================================
// Module  : inputbuf_rd_seq
// Purpose : Read-side address/fold sequencer. Each advance steps the address
//           through 0..DEPTH-1; every address wrap increments the fold, and
//           the wrap of the final fold returns everything to zero.
// Ports   : aclk, aresetn      clock / async active-low reset
//           advance            step strobe (one read issued this cycle)
//           rd_addr, rd_fold   current read position
//           last_of_fold       rd_addr is the final address of a fold
//           last_of_packet     final address of the final fold
// Rev     : 1.0  initial release
// ============================================================================
module inputbuf_rd_seq
  import inputbuf_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int NFOLDS = 8,
  localparam int AW    = width_of(DEPTH),
  localparam int FW    = width_of(NFOLDS)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          advance,
  output logic [AW-1:0] rd_addr,
  output logic [FW-1:0] rd_fold,
  output logic          last_of_fold,
  output logic          last_of_packet
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [FW-1:0] FOLD_LAST = FW'(NFOLDS - 1);

  assign last_of_fold   = (rd_addr == ADDR_LAST);
  assign last_of_packet = last_of_fold && (rd_fold == FOLD_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr <= '0;
      rd_fold <= '0;
    end else if (advance) begin
      if (last_of_fold) begin
        rd_addr <= '0;
        rd_fold <= last_of_packet ? '0 : rd_fold + 1'b1;
      end else begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inputbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inputbuf_ctrl
// Purpose : Control for a two-bank ping-pong input buffer. Upstream words are
//           written into one bank while the other bank is replayed NFOLDS
//           times downstream. No data path: the parent owns the memory and
//           its output register, driven by wr_*/rd_* strobes and addresses.
// Ports   : aclk, aresetn                 clock / async active-low reset
//           s_axis_tvalid/tready          upstream handshake
//           wr_en, wr_bank, wr_addr       memory write port control
//           rd_en, rd_bank, rd_addr       memory read port control
//           rd_fold                       fold index of the current read
//           m_axis_tvalid/tready/tlast    downstream handshake
// Rev     : 1.0  initial release
// ============================================================================
module inputbuf_ctrl
  import inputbuf_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int NFOLDS = 8,
  localparam int AW    = width_of(DEPTH),
  localparam int FW    = width_of(NFOLDS)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic [FW-1:0] rd_fold,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  logic [1:0] full;
  logic [1:0] set_full;
  logic [1:0] clr_full;
  logic       write_done;
  logic       packet_done;
  logic       last_of_fold;
  logic       last_of_packet;

  // Handshakes
  assign s_axis_tready = ~full[wr_bank];
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  // A read is issued when the bank holds a packet and the output register
  // is either empty or being drained this cycle.
  assign rd_en         = full[rd_bank] & (~m_axis_tvalid | m_axis_tready);

  assign write_done  = wr_en && (wr_addr == ADDR_LAST);
  // last_of_packet already implies last_of_fold; both are named here so
  // the packet-end condition reads in full.
  assign packet_done = rd_en && last_of_fold && last_of_packet;

  // Set and clear always target different banks (a bank is only written
  // while empty and only read while full), so both apply on the same edge.
  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (write_done)  set_full[wr_bank] = 1'b1;
    if (packet_done) clr_full[rd_bank] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full <= '0;
    end else begin
      full <= (full | set_full) & ~clr_full;
    end
  end

  // Write sequencing
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_addr <= '0;
      wr_bank <= BANK0;
    end else if (wr_en) begin
      if (write_done) begin
        wr_addr <= '0;
        wr_bank <= (wr_bank == BANK0) ? BANK1 : BANK0;
      end else begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // Read sequencing
  inputbuf_rd_seq #(
    .DEPTH  (DEPTH),
    .NFOLDS (NFOLDS)
  ) u_rd_seq (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .advance        (rd_en),
    .rd_addr        (rd_addr),
    .rd_fold        (rd_fold),
    .last_of_fold   (last_of_fold),
    .last_of_packet (last_of_packet)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_bank <= BANK0;
    end else if (packet_done) begin
      rd_bank <= (rd_bank == BANK0) ? BANK1 : BANK0;
    end
  end

  // Output register status: tlast travels with the data the memory loads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_of_packet;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inputbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_inputbuf_ctrl
// Purpose : Self-checking bench for inputbuf_ctrl. A count-based reference
//           model (writes/reads since reset, packets outstanding) predicts
//           every control output; an expected-beat queue built from the
//           packet order checks what the parent's memory register presents.
//           A second instance (DEPTH=2, NFOLDS=1) checks single-pass mode.
// Rev     : 1.0  initial release
// ============================================================================
module tb_inputbuf_ctrl;

  localparam int D  = 32;
  localparam int N  = 8;
  localparam int DN = D * N;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       wr_en, wr_bank, rd_en, rd_bank;
  logic [4:0] wr_addr, rd_addr;
  logic [2:0] rd_fold;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;

  logic       s_tvalid2 = 1'b0;
  logic       s_tready2, wr_en2, wr_bank2, rd_en2, rd_bank2;
  logic [0:0] wr_addr2, rd_addr2, rd_fold2;
  logic       m_tvalid2;
  logic       m_tready2 = 1'b1;
  logic       m_tlast2;

  always #5 aclk = ~aclk;

  inputbuf_ctrl #(.DEPTH(D), .NFOLDS(N)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_fold(rd_fold),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  inputbuf_ctrl #(.DEPTH(2), .NFOLDS(1)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid2), .s_axis_tready(s_tready2),
    .wr_en(wr_en2), .wr_bank(wr_bank2), .wr_addr(wr_addr2),
    .rd_en(rd_en2), .rd_bank(rd_bank2), .rd_addr(rd_addr2), .rd_fold(rd_fold2),
    .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2),
    .m_axis_tlast(m_tlast2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beat_code(input int bank, input int fold, input int addr);
    return (bank << 16) | (fold << 8) | addr;
  endfunction

  // ---------------- reference model, main instance ----------------
  int wr_cnt = 0;      // write handshakes since reset
  int rd_cnt = 0;      // reads issued since reset
  bit mv = 0;          // output register holds an unconsumed word
  bit mlast = 0;
  int oreg = 0;        // what the parent's memory register would hold
  int n_beats = 0;
  int exp_q[$];
  bit rdy_toggle = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        wr_cnt = 0; rd_cnt = 0; mv = 0; mlast = 0; oreg = 0;
        exp_q.delete();
        check_val("rst_tvalid", int'(m_axis_tvalid), 0);
        check_val("rst_rd_en", int'(rd_en), 0);
        check_val("rst_tready", int'(s_axis_tready), 1);
      end else begin
        int outst;
        bit e_tready, e_wr_en, e_rd_en;
        outst    = wr_cnt / D - rd_cnt / DN;
        e_tready = (outst < 2);
        e_wr_en  = s_axis_tvalid && e_tready;
        e_rd_en  = (outst > 0) && (!mv || m_axis_tready);
        check_val("tready", int'(s_axis_tready), int'(e_tready));
        check_val("wr_en", int'(wr_en), int'(e_wr_en));
        check_val("wr_pos", beat_code(wr_bank, 0, wr_addr),
                  beat_code((wr_cnt / D) % 2, 0, wr_cnt % D));
        check_val("rd_en", int'(rd_en), int'(e_rd_en));
        check_val("rd_pos", beat_code(rd_bank, rd_fold, rd_addr),
                  beat_code((rd_cnt / DN) % 2, (rd_cnt / D) % N, rd_cnt % D));
        check_val("tvalid", int'(m_axis_tvalid), int'(mv));
        if (mv) check_val("tlast", int'(m_axis_tlast), int'(mlast));
        if (m_axis_tvalid && m_axis_tready) begin
          n_beats++;
          if (exp_q.size() == 0) check_val("beat_extra", 1, 0);
          else check_val("beat_order", oreg, exp_q.pop_front());
        end
        // state as of the coming rising edge
        if (rd_en) oreg = beat_code(rd_bank, rd_fold, rd_addr);
        if (e_rd_en) begin
          mv = 1;
          mlast = ((rd_cnt % DN) == DN - 1);
          rd_cnt++;
        end else if (m_axis_tready) begin
          mv = 0;
        end
        if (e_wr_en) begin
          wr_cnt++;
          if (wr_cnt % D == 0)
            for (int f = 0; f < N; f++)
              for (int a = 0; a < D; a++)
                exp_q.push_back(beat_code((wr_cnt / D - 1) % 2, f, a));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (rdy_toggle) m_axis_tready = ~m_axis_tready;
    end
  end

  // ---------------- reference model, single-pass instance ----------------
  int wc2 = 0;
  int beats2 = 0;
  int oreg2 = 0;
  int q2[$];

  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        wc2 = 0; oreg2 = 0; q2.delete();
      end else begin
        if (m_tvalid2 && m_tready2) begin
          int e;
          beats2++;
          if (q2.size() == 0) begin
            check_val("s5_beat_extra", 1, 0);
          end else begin
            e = q2.pop_front();
            check_val("s5_order", oreg2, e);
            check_val("s5_tlast", int'(m_tlast2), int'((e & 1) == 1));
          end
        end
        if (rd_en2) begin
          oreg2 = (int'(rd_bank2) << 1) | int'(rd_addr2);
          check_val("s5_fold", int'(rd_fold2), 0);
        end
        if (wr_en2) begin
          check_val("s5_wr_pos", (int'(wr_bank2) << 1) | int'(wr_addr2),
                    (((wc2 / 2) % 2) << 1) | (wc2 % 2));
          q2.push_back((((wc2 / 2) % 2) << 1) | (wc2 % 2));
          wc2++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_words(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      bit hs = 0;
      s_axis_tvalid = 1'b1;
      while (!hs && waited < 3000) begin
        @(negedge aclk);
        hs = wr_en;
        @(posedge aclk); #1;
        waited++;
      end
      s_axis_tvalid = 1'b0;
      if (!hs) begin
        check_val("wr_timeout", 0, 1);
        return;
      end
      repeat ($urandom_range(0, maxgap)) begin @(posedge aclk); #1; end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  initial begin
    wait_cycles(3);
    // reset state
    check_val("init_tready", int'(s_axis_tready), 1);
    check_val("init_wr_en", int'(wr_en), 0);
    check_val("init_tlast", int'(m_axis_tlast), 0);
    aresetn = 1'b1;
    wait_cycles(2);

    // full-speed single packet, downstream always ready
    send_words(D, 0);
    wait_cycles(DN + 20);
    check_val("s1_beats", n_beats, DN);
    check_val("s1_drain", exp_q.size(), 0);

    // two packets back to back: upstream stalls while both banks full
    send_words(2 * D, 0);
    wait_cycles(2 * DN + 20);
    check_val("s2_beats", n_beats, 3 * DN);
    check_val("s2_drain", exp_q.size(), 0);

    // toggling downstream ready and random upstream gaps
    rdy_toggle = 1'b1;
    send_words(3 * D, 4);
    wait_cycles(4 * DN + 50);
    rdy_toggle = 1'b0;
    @(posedge aclk); #2;
    m_axis_tready = 1'b1;
    wait_cycles(2);
    check_val("s3_beats", n_beats, 6 * DN);
    check_val("s3_drain", exp_q.size(), 0);

    // reset mid-replay at fold 3, address 17
    send_words(D, 0);
    begin
      int waited = 0;
      bit hit = 0;
      while (!hit && waited < 2000) begin
        @(negedge aclk);
        hit = (rd_fold == 3'd3) && (rd_addr == 5'd17);
        waited++;
      end
      check_val("s4_reach_point", int'(hit), 1);
    end
    #1 aresetn = 1'b0;
    #1;
    check_val("s4_tvalid", int'(m_axis_tvalid), 0);
    check_val("s4_tlast", int'(m_axis_tlast), 0);
    check_val("s4_tready", int'(s_axis_tready), 1);
    check_val("s4_rd_en", int'(rd_en), 0);
    check_val("s4_rd_pos", beat_code(rd_bank, rd_fold, rd_addr), 0);
    check_val("s4_wr_pos", beat_code(wr_bank, 0, wr_addr), 0);
    wait_cycles(3);
    aresetn = 1'b1;
    n_beats = 0;
    wait_cycles(20);
    check_val("s4_idle_beats", n_beats, 0);
    send_words(D - 1, 0);
    wait_cycles(5);
    check_val("s4_partial_beats", n_beats, 0);
    send_words(1, 0);
    wait_cycles(DN + 20);
    check_val("s4_beats", n_beats, DN);
    check_val("s4_drain", exp_q.size(), 0);

    // single-pass instance under continuous traffic
    s_tvalid2 = 1'b1;
    wait_cycles(40);
    s_tvalid2 = 1'b0;
    wait_cycles(10);
    check_val("s5_rate", int'(wc2 >= 38), 1);
    check_val("s5_beats", beats2, wc2);
    check_val("s5_drain", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inputbuf_ctrl.md
INPUTBUF_CTRL -- requirements
Module: inputbuf_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32: words per packet and per memory bank; legal range 2 or more.
REQ-002 The block SHALL have parameter NFOLDS, default 8: number of replays of each packet; legal range 1 or more.
REQ-003 The block SHALL derive localparams AW = max(1, clog2(DEPTH)) and FW = max(1, clog2(NFOLDS)).
REQ-004 The block SHALL have one clock, aclk; reset is asynchronous and active-low, aresetn.
REQ-005 aclk  in  1  sole clock; all state changes on its rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 s_axis_tvalid  in  1  upstream word valid.
REQ-008 s_axis_tready  out  1  upstream may transfer; equals NOT full[wr_bank].
REQ-009 wr_en  out  1  memory write strobe; equals s_axis_tvalid AND s_axis_tready.
REQ-010 wr_bank  out  1  bank currently being written.
REQ-011 wr_addr  out  AW  write address in wr_bank.
REQ-012 rd_en  out  1  memory read strobe; the memory output register loads data 1 cycle later and holds it while rd_en is low.
REQ-013 rd_bank  out  1  bank currently being replayed.
REQ-014 rd_addr  out  AW  read address in rd_bank.
REQ-015 rd_fold  out  FW  fold index of the current read.
REQ-016 m_axis_tvalid  out  1  memory output register holds an unconsumed word.
REQ-017 m_axis_tready  in  1  downstream accepts a word.
REQ-018 m_axis_tlast  out  1  the presented word is address DEPTH-1 of fold NFOLDS-1.

Function
REQ-019 Each bank SHALL have a full flag; a write handshake at wr_addr = DEPTH-1 SHALL set full[wr_bank], reset wr_addr to 0 and toggle wr_bank.
REQ-020 rd_en SHALL equal full[rd_bank] AND (NOT m_axis_tvalid OR m_axis_tready).
REQ-021 Each rd_en cycle SHALL advance rd_addr; at DEPTH-1, rd_addr SHALL wrap to 0 and rd_fold SHALL increment.
REQ-022 rd_en at rd_addr = DEPTH-1 with rd_fold = NFOLDS-1 SHALL clear full[rd_bank], zero rd_fold and toggle rd_bank.
REQ-023 m_axis_tvalid SHALL set on the edge at which rd_en is high, and SHALL clear on an edge with m_axis_tready high and rd_en low.
REQ-024 m_axis_tlast SHALL be registered alongside the data under rd_en.
REQ-025 Latency: rd_en SHALL be asserted in the cycle after the DEPTH-th write handshake, with m_axis_tvalid high one cycle later.
REQ-026 With both sides unstalled, the block SHALL sustain one word per cycle on each side.
REQ-027 Writing into one bank SHALL overlap replay of the other; set and clear of different banks on the same edge SHALL both take effect.
REQ-028 With both banks full, s_axis_tready SHALL be low until the replay completes; with both banks empty, rd_en SHALL be low.
REQ-029 When NFOLDS = 1, each packet SHALL be output exactly once.

Reset
REQ-030 While aresetn is low, regardless of aclk, the block SHALL hold:
- both full flags and all counters at 0;
- wr_bank and rd_bank at 0;
- m_axis_tvalid and m_axis_tlast at 0.
REQ-031 Consequently s_axis_tready SHALL read 1, and wr_en and rd_en SHALL read 0.
REQ-032 Reset asserted mid-packet or mid-replay SHALL discard all buffered words, and no word SHALL appear after reset deasserts until a new full packet is written.

Structure
REQ-033 A shared package inputbuf_pkg SHALL hold the clog2-based width function and the bank index constants; inputbuf_ctrl SHALL import it.
REQ-034 The read address/fold counter SHALL be a sub-module inputbuf_rd_seq (inputs: advance strobe; outputs: rd_addr, rd_fold, last_of_fold, last_of_packet).
REQ-035 The block SHALL contain no data path; the data memory is instantiated by the parent.

Verification (DEPTH=32, NFOLDS=8)
REQ-036 Scenario 1: 32 writes at full speed, tready held 1 -> rd_en asserted in the cycle after the 32nd write; 256 consecutive valid beats with addresses 0..31 repeated 8 times; tlast on beat 256 only.
REQ-037 Scenario 2: 64 writes at full speed -> s_axis_tready falls after write 64 and rises in the cycle after the final read of bank 0; the bank 1 replay follows with no gap.
REQ-038 Scenario 3: m_axis_tready toggling every cycle plus random tvalid gaps of 0-4 cycles -> no beat lost or duplicated; output order matches the model; tvalid never drops without a handshake.
REQ-039 Scenario 4: aresetn pulsed low mid-replay (fold 3, address 17) -> all outputs reach reset values immediately without a clock edge; no output appears until 32 new writes complete.
REQ-040 Scenario 5: NFOLDS=1, DEPTH=2, continuous traffic -> output sequence equals input sequence; banks alternate every 2 words.
